input_module: RTL

Operator-input block for the LucioCore processor, the counterpart of the BCD/seven-segment output path. It collects a signed three-digit decimal number from the board (a 4-bit BCD switch bank, a sign switch and a debounced "enter" push-button), converts it to two's-complement binary and delivers it to the core over a 4-phase req/valid handshake. The core raises `req` when it executes an input instruction and stalls until `valid`. The block also exports the digits entered so far so they can be echoed on the displays.

---
 rtl/input_module.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/input_module.sv
// Operator-input block: debounces the enter button, collects three BCD digits
// plus sign, and hands the two's-complement result to the core over req/valid.
module input_module #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            switches,
    input  logic                  sign,
    input  logic                  enter,
    input  logic                  req,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic [1:0]            digit_sel,
    output logic [3:0]            centena,
    output logic [3:0]            dezena,
    output logic [3:0]            unidade,
    output logic                  error
);

    // Handshake: the core holds req high until it sees valid; valid then stays
    // high until req is sampled low, and req may only rise again once valid=0.

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CENT = 3'd1,
        DEZ  = 3'd2,
        UNI  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state;
    logic            sync_a;
    logic            sync_b;
    logic            level;
    logic [CW-1:0]   cnt;
    logic            press;
    logic            digit_ok;
    logic [9:0]      magnitude;
    logic [DATA_WIDTH-1:0] mag_ext;

    assign digit_ok  = (switches <= 4'd9);
    assign magnitude = 10'(centena) * 10'd100 + 10'(dezena) * 10'd10 + 10'(switches);
    assign mag_ext   = {{(DATA_WIDTH-10){1'b0}}, magnitude};

    // press is registered on the same edge the debounced level rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= enter;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync_b;
                cnt   <= '0;
                press <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            data      <= '0;
            valid     <= 1'b0;
            digit_sel <= 2'd3;
            centena   <= 4'd0;
            dezena    <= 4'd0;
            unidade   <= 4'd0;
            error     <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= CENT;
                        digit_sel <= 2'd0;
                        centena   <= 4'd0;
                        dezena    <= 4'd0;
                        unidade   <= 4'd0;
                    end
                end
                CENT: begin
                    if (!req) begin
                        state     <= IDLE;
                        digit_sel <= 2'd3;
                    end else if (press) begin
                        if (digit_ok) begin
                            centena   <= switches;
                            state     <= DEZ;
                            digit_sel <= 2'd1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                DEZ: begin
                    if (!req) begin
                        state     <= IDLE;
                        digit_sel <= 2'd3;
                    end else if (press) begin
                        if (digit_ok) begin
                            dezena    <= switches;
                            state     <= UNI;
                            digit_sel <= 2'd2;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                UNI: begin
                    if (!req) begin
                        state     <= IDLE;
                        digit_sel <= 2'd3;
                    end else if (press) begin
                        if (digit_ok) begin
                            unidade   <= switches;
                            data      <= sign ? (-mag_ext) : mag_ext;
                            valid     <= 1'b1;
                            state     <= DONE;
                            digit_sel <= 2'd3;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!req) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    digit_sel <= 2'd3;
                end
            endcase
        end
    end

endmodule
